phy_strap_seq: RTL and testbench

- Parametrised multi-PHY reset and strap sequencer for the GigE front-end; successor to the single-PHY strap/reset init.
- Drives per-PHY hardware reset plus an arbitrary-width strap bus per PHY (mode, PHYAD, clock enables), holds straps across reset release, then tristates them and waits out the MIIM settle window before asserting ready.
- Supports simultaneous or staggered reset release, software re-initialisation, and optional strap contention readback.

---
 rtl/phy_strap_seq_if.sv | 34 +++
 rtl/phy_strap_seq.sv | 194 +++++++++++++++++++
 tb/tb_phy_strap_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_strap_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : phy_strap_seq_if
//  Description : Strap/reset bundle between the PHY strap sequencer (master)
//                and the pads / host logic (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface phy_strap_seq_if #(
  parameter int N_PHY   = 2,
  parameter int STRAP_W = 10
);
  logic                       reinit;
  logic [N_PHY*STRAP_W-1:0]   strap_val;
  logic [N_PHY*STRAP_W-1:0]   strap_in;
  logic [N_PHY*STRAP_W-1:0]   strap_out;
  logic [N_PHY-1:0]           strap_oe;
  logic [N_PHY-1:0]           phy_hw_rst_n;
  logic                       busy;
  logic                       phy_ready;
  logic [N_PHY-1:0]           strap_err;

  // Sequencer side: drives resets and straps, reads requests and pad readback.
  modport master (
    input  reinit, strap_val, strap_in,
    output strap_out, strap_oe, phy_hw_rst_n, busy, phy_ready, strap_err
  );

  // Pad / host side.
  modport slave (
    output reinit, strap_val, strap_in,
    input  strap_out, strap_oe, phy_hw_rst_n, busy, phy_ready, strap_err
  );
endinterface
`default_nettype wire

// File: rtl/phy_strap_seq.sv
`default_nettype none
// ============================================================================
//  Module      : phy_strap_seq
//  Description : Multi-PHY hardware reset and strap sequencer. Drives straps
//                while PHY resets are held, keeps them through reset release
//                (all at once or one PHY at a time), tristates them, then
//                waits out the MIIM settle window before flagging ready.
//                Optional strap contention readback: PHY_STRAP_READBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_strap_seq #(
  parameter int N_PHY         = 2,
  parameter int STRAP_W       = 10,
  parameter int RST_CYCLES    = 500,
  parameter int HOLD_CYCLES   = 5000,
  parameter int SETTLE_CYCLES = 5000,
  parameter int STAGGER       = 0
) (
  input  logic            clk_50,
  input  logic            reset,
  phy_strap_seq_if.master bus
);

  localparam int MAX_RH = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_RH > SETTLE_CYCLES) ? MAX_RH : SETTLE_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C + 1);
  localparam int CH_W   = (N_PHY > 1) ? $clog2(N_PHY) : 1;
  localparam int SW     = N_PHY * STRAP_W;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_READY  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [SW-1:0]    strap_out_q, strap_out_d;
  logic [N_PHY-1:0] strap_oe_q, strap_oe_d;
  logic [N_PHY-1:0] rst_n_q, rst_n_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             hold_last;

  // Final cycle of a PHY's hold window (readback point, release point).
  assign hold_last = (state_q == ST_HOLD) && (cnt_q == HOLD_LAST) && !bus.reinit;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    strap_out_d = strap_out_q;
    strap_oe_d  = strap_oe_q;
    rst_n_d     = rst_n_q;
    busy_d      = busy_q;
    ready_d     = ready_q;

    if (bus.reinit) begin
      // Restart from scratch; the straps are driven again immediately.
      state_d     = ST_RST;
      cnt_d       = '0;
      ch_d        = '0;
      strap_out_d = bus.strap_val;
      strap_oe_d  = '1;
      rst_n_d     = '0;
      busy_d      = 1'b1;
      ready_d     = 1'b0;
    end else begin
      case (state_q)
        ST_RST: begin
          strap_out_d = bus.strap_val;
          strap_oe_d  = '1;
          rst_n_d     = '0;
          busy_d      = 1'b1;
          ready_d     = 1'b0;
          if (cnt_q == RST_LAST) begin
            cnt_d   = '0;
            ch_d    = '0;
            state_d = ST_HOLD;
            if (STAGGER != 0) rst_n_d[0] = 1'b1;
            else              rst_n_d    = '1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (STAGGER == 0) begin
              strap_oe_d = '0;
              state_d    = ST_SETTLE;
            end else begin
              strap_oe_d[int'(ch_q)] = 1'b0;
              if (int'(ch_q) < N_PHY - 1) begin
                // Hand over to the next PHY: release its reset, new hold window.
                ch_d                     = ch_q + CH_W'(1);
                rst_n_d[int'(ch_q) + 1]  = 1'b1;
              end else begin
                state_d = ST_SETTLE;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = ST_READY;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          strap_oe_d = '0;
          rst_n_d    = '1;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      ch_q        <= '0;
      strap_out_q <= '0;
      strap_oe_q  <= '0;
      rst_n_q     <= '0;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      strap_out_q <= strap_out_d;
      strap_oe_q  <= strap_oe_d;
      rst_n_q     <= rst_n_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.strap_out    = strap_out_q;
  assign bus.strap_oe     = strap_oe_q;
  assign bus.phy_hw_rst_n = rst_n_q;
  assign bus.busy         = busy_q;
  assign bus.phy_ready    = ready_q;

`ifdef PHY_STRAP_READBACK_EN
  logic [N_PHY-1:0] err_q, err_d;

  // Sticky contention flags: pad disagrees with our drive at end of hold.
  always_comb begin
    err_d = err_q;
    if (bus.reinit) begin
      err_d = '0;
    end else if (hold_last) begin
      for (int i = 0; i < N_PHY; i++) begin
        if (((STAGGER == 0) || (i == int'(ch_q))) &&
            (bus.strap_in[i*STRAP_W +: STRAP_W] != strap_out_q[i*STRAP_W +: STRAP_W]))
          err_d[i] = 1'b1;
      end
    end
  end

  // Contention flag register.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign bus.strap_err = err_q;
`else
  logic unused_readback;
  assign unused_readback = (^bus.strap_in) ^ hold_last;
  assign bus.strap_err   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phy_strap_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_strap_seq
//  Description : Bench for phy_strap_seq. Two instances (simultaneous and
//                staggered release) share one stimulus; a timeline model
//                predicts every output each cycle, with literal timing pins.
//                Readback checks enabled by PHY_STRAP_READBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_strap_seq;

  localparam int N = 2;
  localparam int W = 10;
  localparam int R = 8;
  localparam int H = 16;
  localparam int S = 32;

  logic          clk_50;
  logic          reset;
  logic          reinit;
  logic [N*W-1:0] strap_val;
  logic [N*W-1:0] strap_in;

  int n_vec;
  int n_err;
  bit chk_on;

  phy_strap_seq_if #(.N_PHY(N), .STRAP_W(W)) if0 ();
  phy_strap_seq_if #(.N_PHY(N), .STRAP_W(W)) if1 ();

  assign if0.reinit    = reinit;
  assign if0.strap_val = strap_val;
  assign if0.strap_in  = strap_in;
  assign if1.reinit    = reinit;
  assign if1.strap_val = strap_val;
  assign if1.strap_in  = strap_in;

  phy_strap_seq #(.N_PHY(N), .STRAP_W(W), .RST_CYCLES(R), .HOLD_CYCLES(H),
                  .SETTLE_CYCLES(S), .STAGGER(0))
    dut0 (.clk_50(clk_50), .reset(reset), .bus(if0.master));

  phy_strap_seq #(.N_PHY(N), .STRAP_W(W), .RST_CYCLES(R), .HOLD_CYCLES(H),
                  .SETTLE_CYCLES(S), .STAGGER(1))
    dut1 (.clk_50(clk_50), .reset(reset), .bus(if1.master));

  initial begin
    clk_50 = 1'b0;
    forever #5 clk_50 = ~clk_50;
  end

  // ---------------- timeline model ----------------
  // t   : clock edges since the sequence (re)started
  // fr  : sequence started by hardware reset (straps undriven until first edge)
  // cap : strap value the DUT should be driving / holding
  int             t;
  bit             fr;
  logic [N*W-1:0] cap;
  logic [N-1:0]   merr0, merr1;

  always @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      t     <= 0;
      fr    <= 1'b1;
      cap   <= '0;
      merr0 <= '0;
      merr1 <= '0;
    end else if (reinit) begin
      t     <= 0;
      fr    <= 1'b0;
      cap   <= strap_val;
      merr0 <= '0;
      merr1 <= '0;
    end else begin
      if (t < R) cap <= strap_val;
`ifdef PHY_STRAP_READBACK_EN
      for (int i = 0; i < N; i++) begin
        if (strap_in[i*W +: W] != cap[i*W +: W]) begin
          if (t + 1 == R + H)           merr0[i] <= 1'b1;
          if (t + 1 == R + (i + 1) * H) merr1[i] <= 1'b1;
        end
      end
`endif
      if (t < 1000) t <= t + 1;
      fr <= 1'b0;
    end
  end

  function automatic logic [N-1:0] exp_rstn(int st, int tt);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (tt >= R + ((st != 0) ? i * H : 0));
    return v;
  endfunction

  function automatic logic [N-1:0] exp_oe(int st, int tt, bit f);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = !(f && tt == 0) && (tt < R + ((st != 0) ? (i + 1) * H : H));
    return v;
  endfunction

  function automatic logic exp_ready(int st, int tt);
    return tt >= R + ((st != 0) ? N * H : H) + S;
  endfunction

  task automatic cmp(input int id, input logic [N-1:0] rn, input logic [N-1:0] oe,
                     input logic [N*W-1:0] so, input logic b, input logic rd,
                     input logic [N-1:0] er, input logic [N-1:0] eerr);
    logic [N-1:0]   e_rn, e_oe;
    logic [N*W-1:0] e_so;
    logic           e_rd;
    e_rn = exp_rstn(id, t);
    e_oe = exp_oe(id, t, fr);
    e_so = (fr && t == 0) ? '0 : cap;
    e_rd = exp_ready(id, t);
    n_vec++;
    if (rn !== e_rn || oe !== e_oe || so !== e_so || b !== !e_rd || rd !== e_rd || er !== eerr) begin
      n_err++;
      $display("FAIL model_dut%0d t=%0d rstn=%b/%b oe=%b/%b out=%h/%h busy=%b/%b rdy=%b/%b err=%b/%b (actual/expected)",
               id, t, rn, e_rn, oe, e_oe, so, e_so, b, !e_rd, rd, e_rd, er, eerr);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk_50) begin
    if (chk_on) begin
      cmp(0, if0.phy_hw_rst_n, if0.strap_oe, if0.strap_out, if0.busy, if0.phy_ready, if0.strap_err, merr0);
      cmp(1, if1.phy_hw_rst_n, if1.strap_oe, if1.strap_out, if1.busy, if1.phy_ready, if1.strap_err, merr1);
    end
  end

  // ---------------- literal pins ----------------
  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Runs n cycles from a fresh start, checking hand-computed timing points.
  task automatic run_seq(input int n, input logic [N-1:0] err_end);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_50);
      case (k)
        1:  lit("oe_drive",    32'(if0.strap_oe), 32'h3);
        7:  lit("rstn_held",   32'(if0.phy_hw_rst_n), 32'h0);
        8:  begin
              lit("rstn_rel_s0", 32'(if0.phy_hw_rst_n), 32'h3);
              lit("rstn_rel_s1", 32'(if1.phy_hw_rst_n), 32'h1);
            end
        12: strap_val = 20'hFFFFF;
        20: lit("strap_frozen", 32'(if0.strap_out), 32'h0A5F3);
        23: lit("oe_last_hold", 32'(if0.strap_oe), 32'h3);
        24: begin
              lit("oe_drop_s0",  32'(if0.strap_oe), 32'h0);
              lit("rstn1_s1",    32'(if1.phy_hw_rst_n), 32'h3);
              lit("oe0_drop_s1", 32'(if1.strap_oe), 32'h2);
            end
        40: lit("oe1_drop_s1", 32'(if1.strap_oe), 32'h0);
        55: lit("rdy_pre_s0",  32'(if0.phy_ready), 32'h0);
        56: begin
              lit("rdy_s0",  32'(if0.phy_ready), 32'h1);
              lit("busy_s0", 32'(if0.busy), 32'h0);
            end
        71: lit("rdy_pre_s1", 32'(if1.phy_ready), 32'h0);
        72: begin
              lit("rdy_s1",  32'(if1.phy_ready), 32'h1);
              lit("busy_s1", 32'(if1.busy), 32'h0);
              lit("err_s0",  32'(if0.strap_err), 32'(err_end));
              lit("err_s1",  32'(if1.strap_err), 32'(err_end));
            end
        default: ;
      endcase
    end
  endtask

  task automatic pulse_reinit();
    strap_val = 20'h0A5F3;
    reinit    = 1'b1;
    @(negedge clk_50);
    reinit    = 1'b0;
    lit("reinit_rdy",  32'(if0.phy_ready), 32'h0);
    lit("reinit_busy", 32'(if1.busy), 32'h1);
    lit("reinit_rstn", 32'({if0.phy_hw_rst_n, if1.phy_hw_rst_n}), 32'h0);
    lit("reinit_oe",   32'({if0.strap_oe, if1.strap_oe}), 32'hF);
    lit("reinit_err",  32'({if0.strap_err, if1.strap_err}), 32'h0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    chk_on    = 1'b1;
    reset     = 1'b1;
    reinit    = 1'b0;
    strap_val = 20'h0A5F3;
    strap_in  = 20'h0A5F3;

    @(negedge clk_50);
    @(negedge clk_50);
    lit("rst_oe",   32'(if0.strap_oe), 32'h0);
    lit("rst_out",  32'(if1.strap_out), 32'h0);
    lit("rst_busy", 32'(if0.busy), 32'h1);
    reset = 1'b0;

    // Power-up sequence from reset.
    run_seq(80, 2'b00);

    // reinit from READY.
    pulse_reinit();
    run_seq(30, 2'b00);

    // reinit mid-settle (simultaneous instance), then full rerun.
    pulse_reinit();
    run_seq(80, 2'b00);

    // reinit held for several cycles keeps the sequence parked.
    strap_val = 20'h0A5F3;
    reinit    = 1'b1;
    repeat (4) @(negedge clk_50);
    lit("reinit_held_rstn", 32'(if1.phy_hw_rst_n), 32'h0);
    reinit = 1'b0;

    // Async reset mid-hold, off the clock edge.
    run_seq(15, 2'b00);
    @(posedge clk_50);
    #3 reset = 1'b1;
    #1;
    lit("areset_oe",   32'({if0.strap_oe, if1.strap_oe}), 32'h0);
    lit("areset_rstn", 32'({if0.phy_hw_rst_n, if1.phy_hw_rst_n}), 32'h0);
    lit("areset_out",  32'(if0.strap_out), 32'h0);
    lit("areset_busy", 32'({if0.busy, if1.busy}), 32'h3);
    @(negedge clk_50);
    @(negedge clk_50);
    strap_val = 20'h0A5F3;
    reset     = 1'b0;
    run_seq(80, 2'b00);

`ifdef PHY_STRAP_READBACK_EN
    // Pad bit 3 of PHY1 fights the drive.
    strap_in = 20'h0A5F3 ^ 20'h02000;
    pulse_reinit();
    run_seq(80, 2'b10);
    strap_in = 20'h0A5F3;
    pulse_reinit();
    run_seq(80, 2'b00);
`endif

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
